// File: rtl/multicycle_addsub.sv
// Multi-cycle signed add/subtract: an N-bit operation is processed W bits per clock,
// LSB chunk first, through one W-bit adder with the carry registered between chunks.
module multicycle_addsub #(
   parameter int N = 64,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] inp1,
   input  logic [N-1:0] inp2,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_nx_s;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic [N-1:0]   acc_r;
   logic [N-1:0]   acc_nx_s;
   logic [N-1:0]   sum_r;
   logic           carry_r;
   logic           cout_r;
   logic           ovf_r;
   logic           busy_r;
   logic           done_r;
   logic [CW-1:0]  cnt_r;
   logic [W-1:0]   a_chunk_s;
   logic [W-1:0]   b_chunk_s;
   logic [W:0]     add_s;
   logic           msb_cin_s;
   logic           last_s;
   logic           accept_s;

   // Chunk adder and accumulator merge for the chunk selected by the counter
   always_comb begin
      a_chunk_s = a_r[int'(cnt_r) * W +: W];
      b_chunk_s = b_r[int'(cnt_r) * W +: W];
      add_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{W{1'b0}}, carry_r};
      // carry into the chunk MSB recovered from the MSB sum bit
      msb_cin_s = a_chunk_s[W-1] ^ b_chunk_s[W-1] ^ add_s[W-1];
      acc_nx_s  = acc_r;
      acc_nx_s[int'(cnt_r) * W +: W] = add_s[W-1:0];
      last_s    = (cnt_r == CW'(K - 1));
   end

   // Next-state logic and start acceptance
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               state_nx_s = RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand latch, chunk sequencing and result capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r     <= {N{1'b0}};
         b_r     <= {N{1'b0}};
         acc_r   <= {N{1'b0}};
         sum_r   <= {N{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
         if (accept_s) begin
            a_r     <= inp1;
            b_r     <= sub ? ~inp2 : inp2;
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
         end else if (state_r == RUN) begin
            acc_r   <= acc_nx_s;
            carry_r <= add_s[W];
            if (last_s) begin
               cnt_r  <= {CW{1'b0}};
               sum_r  <= acc_nx_s;
               cout_r <= add_s[W];
               ovf_r  <= msb_cin_s ^ add_s[W];
            end else begin
               cnt_r  <= cnt_r + CW'(1);
            end
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule
